// File: rtl/ls_coef_solver_pkg.sv
// ============================================================================
// ls_coef_solver_pkg : constants, FSM states and saturating shift shared by
//                      the regression-path blocks (MAT_INV / XTY / solver).
// Rev 1.0
// ============================================================================
`default_nettype none

package ls_coef_solver_pkg;

  localparam int FRAC_DEF = 6;
  localparam int IW_DEF   = 32;
  localparam int YW_DEF   = 20;
  localparam int OW_DEF   = 32;
  localparam int ACC_W    = IW_DEF + YW_DEF + 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OW_DEF+1){1'b0}}, {(OW_DEF-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OW_DEF+1){1'b1}}, {(OW_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    MAC     = 2'd1,
    OUT     = 2'd2
  } state_e;

  typedef struct packed {
    logic              sat;
    logic [OW_DEF-1:0] val;
  } sat_res_t;

  // Floor toward -inf (arithmetic shift), then clamp to signed OW range.
  function automatic sat_res_t sat_shift(input logic signed [ACC_W-1:0] acc, input int frac);
    logic signed [ACC_W-1:0] sh;
    sat_res_t                r;
    sh    = acc >>> frac;
    r.sat = 1'b0;
    if (sh > SAT_MAX) begin
      sh    = SAT_MAX;
      r.sat = 1'b1;
    end else if (sh < SAT_MIN) begin
      sh    = SAT_MIN;
      r.sat = 1'b1;
    end
    r.val = sh[OW_DEF-1:0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ls_coef_solver_fxp_mac.sv
// ============================================================================
// ls_coef_solver_fxp_mac : signed multiply-accumulate with registered
//                          accumulator and synchronous clear.
// Rev 1.0
// ============================================================================
`default_nettype none

module ls_coef_solver_fxp_mac #(
  parameter int IW = 32,
  parameter int YW = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic signed [IW-1:0]    a_i,
  input  logic signed [YW-1:0]    b_i,
  output logic signed [IW+YW:0]   sum_o
);

  localparam int PW = IW + YW;

  logic signed [PW-1:0] prod;
  logic signed [PW:0]   acc_q;

  assign prod  = PW'(a_i) * PW'(b_i);
  // sum_o is the post-step value; the top forms results from it directly.
  assign sum_o = acc_q + {prod[PW-1], prod};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= sum_o;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ls_coef_solver.sv
// ============================================================================
// ls_coef_solver : beta = inv(X^T X) * (X^T Y) using one shared multiplier
//                  over a four-step MAC sequence.
// Rev 1.0
// ============================================================================
`default_nettype none

module ls_coef_solver
  import ls_coef_solver_pkg::*;
#(
  parameter int IW   = IW_DEF,
  parameter int YW   = YW_DEF,
  parameter int OW   = OW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inv_valid,
  input  logic [IW-1:0] inv_a,
  input  logic [IW-1:0] inv_b,
  input  logic [IW-1:0] inv_c,
  input  logic          xty_valid,
  input  logic [YW-1:0] xty0,
  input  logic [YW-1:0] xty1,
  output logic          in_ready,
  output logic [OW-1:0] beta0,
  output logic [OW-1:0] beta1,
  output logic          sat,
  output logic          o_valid
);

  state_e        state_q;
  logic [1:0]    step_q;
  logic          inv_f_q, xty_f_q;
  logic          inv_f_d, xty_f_d;
  logic          go_d;
  logic [IW-1:0] a_q, b_q, c_q;
  logic [YW-1:0] y0_q, y1_q;
  logic [OW-1:0] beta0_q, beta1_q;
  logic          sat0_q, sat_q;
  logic          o_valid_q, in_ready_q;

  logic [IW-1:0]         mac_a;
  logic [YW-1:0]         mac_b;
  logic                  mac_clr, mac_load;
  logic signed [IW+YW:0] mac_sum;
  sat_res_t              res;

  always_comb begin
    inv_f_d = inv_f_q | inv_valid;
    xty_f_d = xty_f_q | xty_valid;
    go_d    = (state_q != MAC) && inv_f_d && xty_f_d;
    mac_a   = a_q;
    mac_b   = y0_q;
    case (step_q)
      2'd1: begin mac_a = b_q; mac_b = y1_q; end
      2'd2: begin mac_a = b_q; mac_b = y0_q; end
      2'd3: begin mac_a = c_q; mac_b = y1_q; end
      default: ;
    endcase
  end

  // Accumulator restarts after each beta so the two dot products stay independent.
  assign mac_load = (state_q == MAC);
  assign mac_clr  = go_d || ((state_q == MAC) && step_q[0]);
  assign res      = sat_shift(mac_sum, FRAC);

  ls_coef_solver_fxp_mac #(
    .IW (IW),
    .YW (YW)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (mac_clr),
    .load_i (mac_load),
    .a_i    (mac_a),
    .b_i    (mac_b),
    .sum_o  (mac_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      step_q     <= 2'd0;
      inv_f_q    <= 1'b0;
      xty_f_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      beta0_q    <= '0;
      beta1_q    <= '0;
      sat0_q     <= 1'b0;
      sat_q      <= 1'b0;
      o_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        COLLECT, OUT: begin
          // OUT also accepts operands, giving one result every five cycles.
          o_valid_q <= 1'b0;
          if (inv_valid) begin
            a_q <= inv_a;
            b_q <= inv_b;
            c_q <= inv_c;
          end
          if (xty_valid) begin
            y0_q <= xty0;
            y1_q <= xty1;
          end
          if (go_d) begin
            state_q    <= MAC;
            step_q     <= 2'd0;
            inv_f_q    <= 1'b0;
            xty_f_q    <= 1'b0;
            in_ready_q <= 1'b0;
          end else begin
            state_q    <= COLLECT;
            inv_f_q    <= inv_f_d;
            xty_f_q    <= xty_f_d;
            in_ready_q <= 1'b1;
          end
        end
        MAC: begin
          step_q <= step_q + 2'd1;
          if (step_q == 2'd1) begin
            beta0_q <= res.val;
            sat0_q  <= res.sat;
          end
          if (step_q == 2'd3) begin
            beta1_q    <= res.val;
            sat_q      <= sat0_q | res.sat;
            o_valid_q  <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= OUT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign beta0    = beta0_q;
  assign beta1    = beta1_q;
  assign sat      = sat_q;
  assign o_valid  = o_valid_q;

endmodule

`default_nettype wire
